// File: rtl/mips_mc_controller.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects and enables from the latched opcode.
module mips_mc_controller #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int EXTRA_INSTR   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] state,
  output logic       PCEn,
  output logic       lorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTYPE  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_BNE    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t cur;
  state_t dec_next;
  logic   dec_illegal;
  logic   is_ori;
  logic   ready;
  logic   pc_write;
  logic   branch;
  logic   branch_ne;

  assign state = cur;
  assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  always_comb begin
    dec_next    = S_FETCH;
    dec_illegal = 1'b0;
    case (op)
      OP_RTYPE:      dec_next = S_RTYPE;
      OP_LW, OP_SW:  dec_next = S_MEMADR;
      OP_BEQ:        dec_next = S_BEQ;
      OP_ADDI:       dec_next = S_IEXEC;
      OP_J:          dec_next = S_JUMP;
      OP_BNE:
        if (EXTRA_INSTR != 0) dec_next = S_BNE;
        else                  dec_illegal = 1'b1;
      OP_ORI:
        if (EXTRA_INSTR != 0) dec_next = S_IEXEC;
        else                  dec_illegal = 1'b1;
      default:       dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur    <= S_FETCH;
      is_ori <= 1'b0;
    end else begin
      case (cur)
        S_FETCH:  if (ready) cur <= S_DECODE;
        S_DECODE: begin
          is_ori <= (op == OP_ORI) && (EXTRA_INSTR != 0);
          cur    <= dec_next;
        end
        S_MEMADR: cur <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (ready) cur <= S_MEMWB;
        S_MEMWR:  if (ready) cur <= S_FETCH;
        S_RTYPE:  cur <= S_ALUWB;
        S_IEXEC:  cur <= S_IWB;
        S_MEMWB, S_ALUWB, S_IWB, S_BEQ, S_BNE, S_JUMP: cur <= S_FETCH;
        default:  cur <= S_FETCH;
      endcase
    end
  end

  // Controls are decoded from the state register; only the handshake-qualified
  // strobes and the branch-qualified PC enable also look at live inputs.
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    lorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = '0;
    ALUOp      = '0;
    PCSrc      = '0;
    illegal_op = 1'b0;
    if (!reset) begin
      case (cur)
        S_FETCH: begin
          ALUSrcB  = 3'b001;
          IRWrite  = ready;
          pc_write = ready;
        end
        S_DECODE: begin
          ALUSrcB    = 3'b011;
          illegal_op = dec_illegal;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 3'b010;
        end
        S_MEMRD: lorD = 1'b1;
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          lorD     = 1'b1;
          MemWrite = ready;
        end
        S_RTYPE: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BEQ, S_BNE: begin
          ALUSrcA   = 1'b1;
          ALUOp     = 2'b01;
          PCSrc     = 2'b01;
          branch    = (cur == S_BEQ);
          branch_ne = (cur == S_BNE);
        end
        S_IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = is_ori ? 3'b100 : 3'b010;
          ALUOp   = is_ori ? 2'b11 : 2'b00;
        end
        S_IWB: RegWrite = 1'b1;
        S_JUMP: begin
          PCSrc    = 2'b10;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign PCEn = pc_write | (branch & zero) | (branch_ne & ~zero);

endmodule
